// File: rtl/bus_datapath.sv
// bus_datapath
// -----------------------------------------------------------------------------
// Register file and single shared data bus for the 16-bit SimpleCPU. This block
// answers the beat controller's strobes:
//   i* strobes load the current bus value into a register.
//   e* strobes choose which source drives the bus.
// It also presents address, write data and write enable to the data RAM.
//
// Optional feature: define BUS_CONTENTION_CHECK_EN to turn on contention
// checking. When two or more e* strobes are high in the same cycle:
//   - the bus is forced to zero for that cycle, and
//   - the sticky bus_err flag is set.
// Without the macro, the bus is a fixed-priority mux and bus_err is tied to 0.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   idr_0/idr_1/idr_bp/idr_sp   load bus into reg0 / reg1 / bp / sp
//   imar, iaddr, ialu           load bus into mar / address latch / ALU operand B
//   edr_0/edr_1/edr_bp/edr_sp   drive reg0 / reg1 / bp / sp onto the bus
//   emar, eir, ealu, eram       drive mar / {8'h00,IR[7:0]} / alu_din / mem_rdata
//   iir                         load IR from ir_din
//   epc                         load PC from bus
//   ipc                         PC increment request (acts on its rising edge)
//   iram                        RAM write request
//   ir_din, mem_rdata, alu_din  instruction word, RAM read data, ALU result
//   bus, cmd, reg0, alu_b, pc   bus value, IR, reg0, ALU operand B, PC
//   mem_addr, mem_we, mem_wdata RAM address, write enable, write data
//   bus_err                     sticky contention flag
// -----------------------------------------------------------------------------
module bus_datapath #(
  parameter logic [15:0] SP_INIT = 16'h00FF,
  parameter int          ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idr_0,
  input  logic              idr_1,
  input  logic              idr_bp,
  input  logic              idr_sp,
  input  logic              imar,
  input  logic              iaddr,
  input  logic              ialu,
  input  logic              edr_0,
  input  logic              edr_1,
  input  logic              edr_bp,
  input  logic              edr_sp,
  input  logic              emar,
  input  logic              eir,
  input  logic              ealu,
  input  logic              eram,
  input  logic              iir,
  input  logic              epc,
  input  logic              ipc,
  input  logic              iram,
  input  logic [15:0]       ir_din,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       alu_din,
  output logic [15:0]       bus,
  output logic [15:0]       cmd,
  output logic [15:0]       reg0,
  output logic [15:0]       alu_b,
  output logic [15:0]       pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic              bus_err
);

  localparam int DATA_W = 16;

  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] bp;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] mar;
  logic              ipc_q;
  logic [DATA_W-1:0] bus_mux;

  // PC increment wraps naturally at 16 bits (16'hFFFF -> 16'h0000).
  function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
    return v + 16'd1;
  endfunction

  // Fixed-priority bus source select.
  always_comb begin
    bus_mux = '0;
    if (emar)        bus_mux = mar;
    else if (eir)    bus_mux = {8'h00, cmd[7:0]};
    else if (edr_0)  bus_mux = reg0;
    else if (edr_1)  bus_mux = reg1;
    else if (edr_bp) bus_mux = bp;
    else if (edr_sp) bus_mux = sp;
    else if (ealu)   bus_mux = alu_din;
    else if (eram)   bus_mux = mem_rdata;
  end

`ifdef BUS_CONTENTION_CHECK_EN
  logic [7:0] drivers;
  logic       contention;

  assign drivers    = {emar, eir, edr_0, edr_1, edr_bp, edr_sp, ealu, eram};
  assign contention = ($countones(drivers) > 1);

  // A contended cycle puts zero on the bus, so every load that cycle captures zero.
  assign bus = contention ? '0 : bus_mux;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          bus_err <= 1'b0;
    else if (contention) bus_err <= 1'b1;
  end
`else
  assign bus     = bus_mux;
  assign bus_err = 1'b0;
`endif

  assign mem_we    = iram;
  assign mem_wdata = bus;

  // Register file. A register that drives the bus and loads in the same cycle
  // keeps its value. This matters when a higher-priority source (or the
  // contention zeroing) owns the bus in that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg0     <= '0;
      reg1     <= '0;
      bp       <= '0;
      sp       <= SP_INIT;
      mar      <= '0;
      cmd      <= '0;
      pc       <= '0;
      mem_addr <= '0;
      alu_b    <= '0;
      ipc_q    <= 1'b0;
    end else begin
      if (idr_0  && !edr_0)  reg0 <= bus;
      if (idr_1  && !edr_1)  reg1 <= bus;
      if (idr_bp && !edr_bp) bp   <= bus;
      if (idr_sp && !edr_sp) sp   <= bus;
      if (imar   && !emar)   mar  <= bus;
      if (iaddr)             mem_addr <= bus[ADDR_W-1:0];
      if (ialu)              alu_b    <= bus;
      if (iir)               cmd      <= ir_din;
      // A bus load beats an increment arriving in the same cycle.
      if (epc)                 pc <= bus;
      else if (ipc && !ipc_q)  pc <= inc_wrap(pc);
      ipc_q <= ipc;
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Testbench for bus_datapath: directed steps from the test plan followed by
// randomized strobe traffic, all checked against a behavioural model.
module tb_bus_datapath;

  localparam logic [15:0] SP_INIT = 16'h00FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        idr_0, idr_1, idr_bp, idr_sp, imar, iaddr, ialu;
  logic        edr_0, edr_1, edr_bp, edr_sp, emar, eir, ealu, eram;
  logic        iir, epc, ipc, iram;
  logic [15:0] ir_din, mem_rdata, alu_din;
  logic [15:0] bus, cmd, reg0, alu_b, pc, mem_wdata;
  logic [7:0]  mem_addr;
  logic        mem_we, bus_err;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [15:0] m_reg0, m_reg1, m_bp, m_sp, m_mar, m_ir, m_pc, m_alub;
  logic [7:0]  m_addr;
  logic        m_ipc_prev, m_err;

  bus_datapath #(.SP_INIT(SP_INIT), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .idr_0(idr_0), .idr_1(idr_1), .idr_bp(idr_bp), .idr_sp(idr_sp),
    .imar(imar), .iaddr(iaddr), .ialu(ialu),
    .edr_0(edr_0), .edr_1(edr_1), .edr_bp(edr_bp), .edr_sp(edr_sp),
    .emar(emar), .eir(eir), .ealu(ealu), .eram(eram),
    .iir(iir), .epc(epc), .ipc(ipc), .iram(iram),
    .ir_din(ir_din), .mem_rdata(mem_rdata), .alu_din(alu_din),
    .bus(bus), .cmd(cmd), .reg0(reg0), .alu_b(alu_b), .pc(pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .bus_err(bus_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {idr_0, idr_1, idr_bp, idr_sp, imar, iaddr, ialu} = '0;
    {edr_0, edr_1, edr_bp, edr_sp, emar, eir, ealu, eram} = '0;
    {iir, epc, ipc, iram} = '0;
  endtask

  // Bus model: the first active source in the priority list wins. With the
  // contention check enabled, any cycle with more than one source reads zero.
  function automatic logic [15:0] model_bus(output bit contended);
    bit          en[8];
    logic [15:0] val[8];
    int          n;
    logic [15:0] r;
    en  = '{emar, eir, edr_0, edr_1, edr_bp, edr_sp, ealu, eram};
    val = '{m_mar, {8'h00, m_ir[7:0]}, m_reg0, m_reg1, m_bp, m_sp, alu_din, mem_rdata};
    n = 0;
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        if (n == 0) r = val[i];
        n++;
      end
    end
    contended = (n > 1);
`ifdef BUS_CONTENTION_CHECK_EN
    if (contended) r = 16'h0000;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_reg0 = 0; m_reg1 = 0; m_bp = 0; m_sp = SP_INIT; m_mar = 0;
    m_ir = 0; m_pc = 0; m_alub = 0; m_addr = 0; m_ipc_prev = 0; m_err = 0;
  endtask

  // Model of one clock edge, using the inputs that are present at that edge.
  task automatic model_edge();
    bit          c;
    logic [15:0] b;
    b = model_bus(c);
    if (idr_0  && !edr_0)  m_reg0 = b;
    if (idr_1  && !edr_1)  m_reg1 = b;
    if (idr_bp && !edr_bp) m_bp   = b;
    if (idr_sp && !edr_sp) m_sp   = b;
    if (imar   && !emar)   m_mar  = b;
    if (iaddr) m_addr = b[7:0];
    if (ialu)  m_alub = b;
    if (iir)   m_ir   = ir_din;
    if (epc) m_pc = b;
    else if (ipc && !m_ipc_prev) m_pc = 16'((32'(m_pc) + 1) % 65536);
    m_ipc_prev = ipc;
`ifdef BUS_CONTENTION_CHECK_EN
    if (c) m_err = 1'b1;
`endif
  endtask

  task automatic check_regs();
    check("cmd", cmd, m_ir);
    check("reg0", reg0, m_reg0);
    check("alu_b", alu_b, m_alub);
    check("pc", pc, m_pc);
    check("mem_addr", {8'h00, mem_addr}, {8'h00, m_addr});
    check("bus_err", {15'h0, bus_err}, {15'h0, m_err});
  endtask

  task automatic check_comb();
    bit c;
    check("bus", bus, model_bus(c));
    check("mem_we", {15'h0, mem_we}, {15'h0, iram});
    check("mem_wdata", mem_wdata, model_bus(c));
  endtask

  // Drive each register onto the bus on its own, so that registers without a
  // dedicated output can be observed.
  task automatic peek_all();
    bit c;
    {edr_0, edr_1, edr_bp, edr_sp, emar, eir, ealu, eram} = '0;
    edr_0  = 1; #1; check("peek_reg0", bus, m_reg0); edr_0  = 0;
    edr_1  = 1; #1; check("peek_reg1", bus, m_reg1); edr_1  = 0;
    edr_bp = 1; #1; check("peek_bp",   bus, m_bp);   edr_bp = 0;
    edr_sp = 1; #1; check("peek_sp",   bus, m_sp);   edr_sp = 0;
    emar   = 1; #1; check("peek_mar",  bus, m_mar);  emar   = 0;
    eir    = 1; #1; check("peek_ir",   bus, {8'h00, m_ir[7:0]}); eir = 0;
    c = 0;
  endtask

  // One bus cycle. The caller has already set the inputs, and this task is
  // entered well before the next rising edge.
  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    peek_all();
  endtask

  initial begin
    clear_inputs();
    ir_din = 0; mem_rdata = 0; alu_din = 0;
    reset = 1'b0;
    model_reset();
    #25;
    check_regs();
    check("reset_bus", bus, 16'h0000);
    peek_all();
    check("reset_sp_const", m_sp, SP_INIT);
    reset = 1'b1;
    @(posedge clk); #1;

    // cp transfer: reg1 <- 1234 from RAM data, then reg0 <- reg1
    clear_inputs(); eram = 1; mem_rdata = 16'h1234; idr_1 = 1; cycle();
    clear_inputs(); edr_1 = 1; idr_0 = 1; cycle();
    check("cp_reg0", reg0, 16'h1234);

    // st then ld
    clear_inputs(); eram = 1; mem_rdata = 16'h0042; imar = 1; cycle();
    clear_inputs(); emar = 1; iaddr = 1; cycle();
    check("st_addr", {8'h00, mem_addr}, 16'h0042);
    clear_inputs(); eram = 1; mem_rdata = 16'hBEEF; idr_0 = 1; cycle();
    clear_inputs(); edr_0 = 1; iram = 1; #1;
    check("st_we", {15'h0, mem_we}, 16'h0001);
    check("st_wdata", mem_wdata, 16'hBEEF);
    cycle();
    clear_inputs(); eram = 1; mem_rdata = 16'hBEEF; idr_bp = 1; cycle();
    clear_inputs(); edr_bp = 1; #1; check("ld_bp", bus, 16'hBEEF);

    // PC: wrap from FFFF with ipc held for three cycles
    clear_inputs(); eram = 1; mem_rdata = 16'hFFFF; epc = 1; cycle();
    check("pc_ffff", pc, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); ipc = 1; cycle();
    end
    check("pc_wrap_once", pc, 16'h0000);
    clear_inputs(); cycle();
    clear_inputs(); eram = 1; mem_rdata = 16'h0010; epc = 1; ipc = 1; cycle();
    check("pc_load_wins", pc, 16'h0010);

    // ALU operand path
    clear_inputs(); eram = 1; mem_rdata = 16'h0005; idr_bp = 1; cycle();
    clear_inputs(); edr_bp = 1; ialu = 1; cycle();
    check("alu_b_5", alu_b, 16'h0005);
    clear_inputs(); ealu = 1; alu_din = 16'h000A; idr_0 = 1; cycle();
    check("alu_reg0", reg0, 16'h000A);

    // Contention: emar + edr_0 together
    clear_inputs(); emar = 1; edr_0 = 1; #1;
`ifdef BUS_CONTENTION_CHECK_EN
    check("cont_bus", bus, 16'h0000);
`else
    check("cont_bus", bus, m_mar);
`endif
    cycle();
    clear_inputs(); cycle();
`ifdef BUS_CONTENTION_CHECK_EN
    check("cont_err_sticky", {15'h0, bus_err}, 16'h0001);
`else
    check("cont_err_zero", {15'h0, bus_err}, 16'h0000);
`endif

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      clear_inputs();
      {idr_0, idr_1, idr_bp, idr_sp} = {($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0),
                                        ($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0)};
      {imar, iaddr, ialu, iir} = {($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0),
                                  ($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0)};
      {epc, ipc, iram} = {($urandom_range(0,5) == 0), ($urandom_range(0,1) == 0),
                          ($urandom_range(0,3) == 0)};
      {edr_0, edr_1, edr_bp, edr_sp} = {($urandom_range(0,6) == 0), ($urandom_range(0,6) == 0),
                                        ($urandom_range(0,6) == 0), ($urandom_range(0,6) == 0)};
      {emar, eir, ealu, eram} = {($urandom_range(0,6) == 0), ($urandom_range(0,6) == 0),
                                 ($urandom_range(0,4) == 0), ($urandom_range(0,2) == 0)};
      ir_din = 16'($urandom); mem_rdata = 16'($urandom); alu_din = 16'($urandom);
      cycle();
    end

    // Reset asserted in the middle of a transfer, held across an edge with strobes active
    clear_inputs(); eram = 1; mem_rdata = 16'hABCD; idr_0 = 1; idr_1 = 1; idr_sp = 1;
    ialu = 1; iaddr = 1; iir = 1; ir_din = 16'h5A5A; epc = 1;
    #1; reset = 1'b0; #1;
    model_reset();
    check_regs();
    @(posedge clk); #1;
    check("rst_hold_reg0", reg0, 16'h0000);
    check("rst_hold_pc", pc, 16'h0000);
    check("rst_hold_cmd", cmd, 16'h0000);
    clear_inputs();
    peek_all();
    #3; reset = 1'b1;
    @(posedge clk); #1;
    check_regs();
    peek_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
